// File: rtl/mem_copy_engine_pkg.sv
// Shared types and default sizes for the memory copy engine.
// Build option: define MEMCPY_CHECKSUM_EN to enable the running checksum.
package memcpy_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 64;

    typedef enum logic [1:0] {
        IDLE,
        RD,
        WR,
        DONE
    } state_t;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Control handshake and data-memory port of the copy engine.
// master = the engine itself, slave = software/testbench plus memory.
interface mem_copy_engine_if #(
    parameter int ADDR_W = memcpy_pkg::ADDR_W,
    parameter int DATA_W = memcpy_pkg::DATA_W
) ();

    logic              start;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W-1:0] len;
    logic              busy;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] checksum;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_w_en;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        input  start, src_addr, dst_addr, len, mem_rdata,
        output busy, done, err, checksum, mem_addr, mem_wdata, mem_w_en
    );

    modport slave (
        output start, src_addr, dst_addr, len, mem_rdata,
        input  busy, done, err, checksum, mem_addr, mem_wdata, mem_w_en
    );

endinterface

// File: rtl/mem_copy_engine.sv
// Simple DMA: forward word-by-word copy, one word every two cycles.
// Build option: MEMCPY_CHECKSUM_EN adds a mod-2^DATA_W sum of copied words.
module mem_copy_engine
    import memcpy_pkg::*;
#(
    parameter int DATA_W = memcpy_pkg::DATA_W,
    parameter int ADDR_W = memcpy_pkg::ADDR_W,
    parameter int DEPTH  = memcpy_pkg::DEPTH
) (
    input logic              clk,
    input logic              rst,
    mem_copy_engine_if.master bus
);

    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

    state_t            state_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] idx_q;
    logic [DATA_W-1:0] data_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wen_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;
`ifdef MEMCPY_CHECKSUM_EN
    logic [DATA_W-1:0] cks_q;
`endif

    logic [ADDR_W:0] src_end;
    logic [ADDR_W:0] dst_end;
    logic            range_bad;
    logic            last_word;

    // End addresses one bit wider so src+len never wraps past DEPTH.
    assign src_end   = {1'b0, bus.src_addr} + {1'b0, bus.len};
    assign dst_end   = {1'b0, bus.dst_addr} + {1'b0, bus.len};
    assign range_bad = (src_end > LIMIT) || (dst_end > LIMIT);
    assign last_word = (ADDR_W'(idx_q + ADDR_W'(1)) == len_q);

    // Copy FSM; every bus output comes straight from a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef MEMCPY_CHECKSUM_EN
            cks_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        src_q <= bus.src_addr;
                        dst_q <= bus.dst_addr;
                        len_q <= bus.len;
                        idx_q <= '0;
                        err_q <= 1'b0;
`ifdef MEMCPY_CHECKSUM_EN
                        cks_q <= '0;
`endif
                        if (range_bad) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (bus.len == '0) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            addr_q  <= bus.src_addr;
                            state_q <= RD;
                        end
                    end
                end
                RD: begin
                    data_q  <= bus.mem_rdata;
                    addr_q  <= dst_q + idx_q;
                    wen_q   <= 1'b1;
`ifdef MEMCPY_CHECKSUM_EN
                    cks_q   <= cks_q + bus.mem_rdata;
`endif
                    state_q <= WR;
                end
                WR: begin
                    idx_q  <= idx_q + ADDR_W'(1);
                    wen_q  <= 1'b0;
                    data_q <= '0;
                    if (last_word) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        addr_q  <= '0;
                        state_q <= DONE;
                    end else begin
                        addr_q  <= src_q + idx_q + ADDR_W'(1);
                        state_q <= RD;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = data_q;
    assign bus.mem_w_en  = wen_q;
`ifdef MEMCPY_CHECKSUM_EN
    assign bus.checksum  = cks_q;
`else
    assign bus.checksum  = '0;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine with a behavioural memory
// and a forward-copy reference model.
module tb_mem_copy_engine;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mem_copy_engine_if bus ();

    mem_copy_engine dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [15:0] mem     [64];
    logic [15:0] ref_mem [64];

    int errors = 0;
    int checks = 0;

    // Memory: combinational read, write on falling edge.
    assign bus.mem_rdata = (bus.mem_addr < 8'd64) ? mem[bus.mem_addr[5:0]] : 16'h0;

    always @(negedge clk) begin
        if (bus.mem_w_en && bus.mem_addr < 8'd64)
            mem[bus.mem_addr[5:0]] = bus.mem_wdata;
    end

    function automatic int mem_diffs();
        int n = 0;
        for (int i = 0; i < 64; i++)
            if (mem[i] !== ref_mem[i]) n++;
        return n;
    endfunction

    // Reference: sequential forward copy, straight from the request rules.
    function automatic void model(input int s, input int d, input int l,
                                  output logic e, output logic [15:0] cks,
                                  output int dcyc, output int wen);
        e = ((s + l) > 64) || ((d + l) > 64);
        cks = 16'h0;
        if (e || l == 0) begin
            dcyc = 1;
            wen  = 0;
        end else begin
            dcyc = 2 * l + 1;
            wen  = l;
            for (int k = 0; k < l; k++) begin
                ref_mem[d + k] = ref_mem[s + k];
                cks = cks + ref_mem[s + k];
            end
        end
`ifndef MEMCPY_CHECKSUM_EN
        cks = 16'h0;
`endif
    endfunction

    task automatic xfer(input logic [7:0] s, input logic [7:0] d,
                        input logic [7:0] l, input int ncyc, input int rc,
                        input logic [7:0] s2, input logic [7:0] d2,
                        input logic [7:0] l2,
                        output int dcyc, output int dcnt, output int wcnt,
                        output int bcnt, output logic e, output logic [15:0] cks);
        dcyc = 0; dcnt = 0; wcnt = 0; bcnt = 0; e = 1'b0; cks = 16'h0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.src_addr = s;
        bus.dst_addr = d;
        bus.len = l;
        @(posedge clk);
        #1;
        for (int c = 1; c <= ncyc; c++) begin
            if (c == rc) begin
                bus.start = 1'b1;
                bus.src_addr = s2;
                bus.dst_addr = d2;
                bus.len = l2;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                dcnt++;
                if (dcyc == 0) begin
                    dcyc = c;
                    e = bus.err;
                    cks = bus.checksum;
                end
            end
            if (bus.mem_w_en) wcnt++;
            if (bus.busy) bcnt++;
            @(posedge clk);
            #1;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.err, bus.mem_w_en} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b want=0000",
                     {bus.busy, bus.done, bus.err, bus.mem_w_en});
        end
        checks++;
        if (bus.mem_addr !== 8'h0 || bus.mem_wdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_bus addr=%h wdata=%h want 0", bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (bus.checksum !== 16'h0) begin
            errors++;
            $display("FAIL reset_cks got=%h want=0", bus.checksum);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int dc, dn, wc, bc, xd, xw;
        logic e, xe;
        logic [15:0] ck, xc;
        for (int i = 0; i < 4; i++) begin
            mem[i] = 16'(i + 1);
            ref_mem[i] = 16'(i + 1);
        end
        model(0, 10, 4, xe, xc, xd, xw);
        xfer(8'd0, 8'd10, 8'd4, 12, 0, 8'd0, 8'd0, 8'd0, dc, dn, wc, bc, e, ck);
        checks++;
        if (dc !== 9 || dn !== 1) begin
            errors++;
            $display("FAIL basic_done cyc=%0d cnt=%0d want 9/1", dc, dn);
        end
        checks++;
        if (wc !== 4 || bc !== 8) begin
            errors++;
            $display("FAIL basic_wen wen=%0d busy=%0d want 4/8", wc, bc);
        end
        checks++;
        if (e !== 1'b0) begin
            errors++;
            $display("FAIL basic_err got=%b want=0", e);
        end
        checks++;
        if (ck !== xc) begin
            errors++;
            $display("FAIL basic_cks got=%0d want=%0d", ck, xc);
        end
        checks++;
        if (mem[10] !== 16'd1 || mem[11] !== 16'd2 || mem[12] !== 16'd3 || mem[13] !== 16'd4) begin
            errors++;
            $display("FAIL basic_data got=%0d,%0d,%0d,%0d want 1,2,3,4",
                     mem[10], mem[11], mem[12], mem[13]);
        end
        checks++;
        if (mem_diffs() !== 0) begin
            errors++;
            $display("FAIL basic_mem diffs=%0d want 0", mem_diffs());
        end
    endtask

    task automatic test_len0();
        int dc, dn, wc, bc;
        logic e;
        logic [15:0] ck;
        xfer(8'd5, 8'd6, 8'd0, 4, 0, 8'd0, 8'd0, 8'd0, dc, dn, wc, bc, e, ck);
        checks++;
        if (dc !== 1 || dn !== 1 || e !== 1'b0) begin
            errors++;
            $display("FAIL len0_done cyc=%0d cnt=%0d err=%b want 1/1/0", dc, dn, e);
        end
        checks++;
        if (wc !== 0 || bc !== 0) begin
            errors++;
            $display("FAIL len0_idle wen=%0d busy=%0d want 0/0", wc, bc);
        end
    endtask

    task automatic test_range_err();
        int dc, dn, wc, bc, xd, xw;
        logic e, xe;
        logic [15:0] ck, xc;
        model(60, 0, 5, xe, xc, xd, xw);
        xfer(8'd60, 8'd0, 8'd5, 4, 0, 8'd0, 8'd0, 8'd0, dc, dn, wc, bc, e, ck);
        checks++;
        if (dc !== 1 || e !== 1'b1 || xe !== 1'b1) begin
            errors++;
            $display("FAIL err_done cyc=%0d err=%b want 1/1", dc, e);
        end
        checks++;
        if (wc !== 0 || mem_diffs() !== 0) begin
            errors++;
            $display("FAIL err_nowrite wen=%0d diffs=%0d want 0/0", wc, mem_diffs());
        end
        checks++;
        if (bus.err !== 1'b1) begin
            errors++;
            $display("FAIL err_hold got=%b want=1", bus.err);
        end
        model(1, 40, 2, xe, xc, xd, xw);
        xfer(8'd1, 8'd40, 8'd2, 8, 0, 8'd0, 8'd0, 8'd0, dc, dn, wc, bc, e, ck);
        checks++;
        if (e !== 1'b0 || bus.err !== 1'b0 || dc !== xd) begin
            errors++;
            $display("FAIL err_clear err=%b/%b cyc=%0d want 0/0/%0d", e, bus.err, dc, xd);
        end
    endtask

    task automatic test_overlap();
        int dc, dn, wc, bc, xd, xw;
        logic e, xe;
        logic [15:0] ck, xc;
        for (int i = 0; i < 3; i++) begin
            mem[20 + i] = 16'(7 + i);
            ref_mem[20 + i] = 16'(7 + i);
        end
        model(20, 21, 2, xe, xc, xd, xw);
        xfer(8'd20, 8'd21, 8'd2, 8, 0, 8'd0, 8'd0, 8'd0, dc, dn, wc, bc, e, ck);
        checks++;
        if (mem[21] !== 16'd7 || mem[22] !== 16'd7) begin
            errors++;
            $display("FAIL overlap_data got=%0d,%0d want 7,7", mem[21], mem[22]);
        end
        checks++;
        if (ck !== xc || dc !== xd) begin
            errors++;
            $display("FAIL overlap_cks cks=%0d cyc=%0d want %0d/%0d", ck, dc, xc, xd);
        end
    endtask

    task automatic test_ignore_start();
        int dc, dn, wc, bc, xd, xw;
        logic e, xe;
        logic [15:0] ck, xc;
        model(0, 30, 4, xe, xc, xd, xw);
        xfer(8'd0, 8'd30, 8'd4, 12, 3, 8'd5, 8'd50, 8'd3, dc, dn, wc, bc, e, ck);
        checks++;
        if (dn !== 1 || wc !== 4 || dc !== 9) begin
            errors++;
            $display("FAIL ignore_start done=%0d wen=%0d cyc=%0d want 1/4/9", dn, wc, dc);
        end
        checks++;
        if (mem_diffs() !== 0) begin
            errors++;
            $display("FAIL ignore_mem diffs=%0d want 0", mem_diffs());
        end
    endtask

    task automatic test_reset_mid();
        int dn, dc, wc, bc;
        logic e;
        logic [15:0] ck;
        for (int i = 0; i < 4; i++) begin
            mem[30 + i] = 16'($urandom);
            ref_mem[30 + i] = mem[30 + i];
        end
        @(negedge clk);
        bus.start = 1'b1;
        bus.src_addr = 8'd30;
        bus.dst_addr = 8'd40;
        bus.len = 8'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        checks++;
        if (bus.mem_w_en !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_outs wen=%b busy=%b done=%b want 0/0/0",
                     bus.mem_w_en, bus.busy, bus.done);
        end
        @(negedge clk);
        rst = 1'b0;
        ref_mem[40] = ref_mem[30];
        dn = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (bus.done) dn++;
        end
        checks++;
        if (dn !== 0 || mem_diffs() !== 0) begin
            errors++;
            $display("FAIL midrst_mem done=%0d diffs=%0d want 0/0", dn, mem_diffs());
        end
        xfer(8'd0, 8'd0, 8'd0, 3, 0, 8'd0, 8'd0, 8'd0, dc, dn, wc, bc, e, ck);
        checks++;
        if (dc !== 1) begin
            errors++;
            $display("FAIL midrst_idle cyc=%0d want 1", dc);
        end
    endtask

    task automatic test_random();
        int dc, dn, wc, bc, xd, xw, s, d, l;
        logic e, xe;
        logic [15:0] ck, xc;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 16'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int it = 0; it < 12; it++) begin
            s = $urandom_range(0, 66);
            d = $urandom_range(0, 66);
            l = $urandom_range(0, 10);
            model(s, d, l, xe, xc, xd, xw);
            xfer(8'(s), 8'(d), 8'(l), 2 * l + 3, 0, 8'd0, 8'd0, 8'd0,
                 dc, dn, wc, bc, e, ck);
            checks++;
            if (dc !== xd || dn !== 1 || wc !== xw || e !== xe || ck !== xc) begin
                errors++;
                $display("FAIL rand_%0d s=%0d d=%0d l=%0d cyc=%0d/%0d cnt=%0d wen=%0d/%0d err=%b/%b cks=%h/%h",
                         it, s, d, l, dc, xd, dn, wc, xw, e, xe, ck, xc);
            end
            checks++;
            if (mem_diffs() !== 0) begin
                errors++;
                $display("FAIL rand_mem_%0d diffs=%0d want 0", it, mem_diffs());
                for (int i = 0; i < 64; i++) ref_mem[i] = mem[i];
            end
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.src_addr = '0;
        bus.dst_addr = '0;
        bus.len = '0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 16'(i * 3 + 100);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_basic();
        test_len0();
        test_range_err();
        test_overlap();
        test_ignore_start();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Bus initiator that drives the data memory's port (addr, wdata, w_en, rdata) to copy a block of 16-bit words from a source to a destination region.
- Sits beside the datapath as a simple DMA. Software/testbench pulses start with src/dst/len, waits for done.
- Targets a memory with a combinational read path and writes committed on the falling clock edge.

Parameters:
- DATA_W, 16, memory word width
- ADDR_W, 8, memory address width
- DEPTH, 64, number of valid memory words; addresses >= DEPTH are illegal

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- src_addr  in  ADDR_W  first source word address
- dst_addr  in  ADDR_W  first destination word address
- len  in  ADDR_W  number of words to copy (0 legal)
- busy  out  1  high in RD/WR states
- done  out  1  one-cycle pulse at end of every accepted request
- err  out  1  range error flag, valid with done, held until next accepted start
- checksum  out  DATA_W  modulo-2^16 sum of copied words (see Optional Feature)
- mem_addr  out  ADDR_W  to memory addr
- mem_wdata  out  DATA_W  to memory wdata
- mem_w_en  out  1  to memory w_en
- mem_rdata  in  DATA_W  from memory rdata

Behaviour:
- States: IDLE, RD, WR, DONE. Internal registers: src_q, dst_q, len_q, idx, data_q.
- Reset (async, immediate): state=IDLE; busy=0, done=0, err=0, checksum=0, mem_w_en=0, mem_addr=0, mem_wdata=0; idx=0.
- IDLE: on rising edge with start=1, latch src/dst/len, clear err and checksum, idx=0.
  - If src+len > DEPTH or dst+len > DEPTH (computed ADDR_W+1 bits wide, no wrap), set err=1 and go to DONE. No memory access occurs.
  - Else if len=0, go to DONE with err=0.
  - Else go to RD.
- RD: mem_addr=src_q+idx, mem_w_en=0. On the edge, data_q<=mem_rdata, then go to WR.
- WR: mem_addr=dst_q+idx, mem_wdata=data_q, mem_w_en=1. The memory commits on the falling edge inside this cycle.
  - On the edge, idx<=idx+1.
  - If idx+1==len_q, go to DONE; else go to RD.
- DONE: done=1 for exactly this cycle, busy=0, mem_w_en=0. Next edge returns to IDLE.
- Memory port outputs are decoded from registered state only, with no combinational path from start/src/dst/len. Outside WR, mem_w_en=0 and mem_wdata holds 0.
- Latency: acceptance edge E0. Word k is read in cycle 2k+1 and written in cycle 2k+2. done is high in cycle 2*len+1; for len=0 or err, done is high in cycle 1.
- Throughput: one word per 2 cycles. Minimum gap between requests is 1 IDLE cycle after DONE.
- start while not IDLE is ignored, not queued.
- Overlap: strictly ascending per-word copy. Each word is read after all prior writes, so the result is defined as a sequential forward copy. For example, dst=src+1 replicates src[0] across the range.
- Reset mid-transfer aborts immediately. Words already written stay written, no done pulse is produced, and no write occurs in the reset cycle.

Optional Feature:
- Macro MEMCPY_CHECKSUM_EN.
- Defined: in each RD cycle, checksum <= checksum + mem_rdata (mod 2^16). checksum is cleared on an accepted start and is stable from DONE until the next accepted start.
- Undefined: checksum is tied to 0 and no adder is built.

Decomposition:
- Package memcpy_pkg holds the state enum (IDLE, RD, WR, DONE) and the DATA_W/ADDR_W/DEPTH default constants.
- No sub-module is needed. The FSM, counter and range check fit one module. The range comparator may be a function in the package.

Test Plan:
- Preload mem[0..3]=1,2,3,4; start src=0 dst=10 len=4 -> mem[10..13]=1,2,3,4, done pulses once in cycle 9, err=0, exactly 4 w_en cycles; checksum=10 with MEMCPY_CHECKSUM_EN, else 0.
- start len=0 -> done in cycle 1, busy never high, mem_w_en never high.
- start src=60 dst=0 len=5 (60+5>64) -> err=1 with done in cycle 1, no memory writes; err clears on the next valid start.
- Overlap: mem[20..22]=7,8,9; src=20 dst=21 len=2 -> mem[21]=7, mem[22]=7.
- Assert start again during busy with different args -> ignored; only the first transfer's writes occur, one done pulse.
- Assert rst in cycle 4 of a len=4 copy -> mem_w_en drops immediately, state IDLE, only word 0 (and word 1 if its WR completed) written, no done.
